// File: rtl/bt_rx_if.sv
// -----------------------------------------------------------------------------
// bt_rx_if -- signal bundle between the Bluetooth serial line / game-control
// logic and the bt_rx UART receiver.
//
//   rxd         serial line, idle high, LSB first (line side -> receiver)
//   data        last received data field, good or bad frame
//   valid       one-cycle pulse: clean frame present in data
//   parity_err  one-cycle pulse: parity mismatch
//   frame_err   one-cycle pulse: a stop bit sampled 0
//   busy        receiver is inside a frame
//   choice/dir  high/low nibble of the last clean frame
//
// Modports: master = line driver / consumer side, slave = the receiver.
// DATA_BITS must match the DATA_BITS of the bt_rx instance bound to it.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

interface bt_rx_if #(
   parameter int DATA_BITS = 8
);
   logic                 rxd;
   logic [DATA_BITS-1:0] data;
   logic                 valid;
   logic                 parity_err;
   logic                 frame_err;
   logic                 busy;
   logic [3:0]           choice;
   logic [3:0]           dir;

   modport master (
      output rxd,
      input  data, valid, parity_err, frame_err, busy, choice, dir
   );

   modport slave (
      input  rxd,
      output data, valid, parity_err, frame_err, busy, choice, dir
   );
endinterface

// File: rtl/bt_rx.sv
// -----------------------------------------------------------------------------
// bt_rx -- parametrised UART receiver for the Bluetooth control link.
//
// Ports:
//   clk   system clock, all logic on the rising edge
//   rst   asynchronous, active-low reset (discards any frame in flight)
//   bus   bt_rx_if.slave: rxd in; data/valid/parity_err/frame_err/busy/
//         choice/dir out (see bt_rx_if.sv)
//
// Parameters: CLK_HZ, BAUD (DIV = rounded CLK_HZ/BAUD), DATA_BITS (5..8),
// PARITY (0 none, 1 odd, 2 even), STOP_BITS (1 or 2).
//
// Optional feature macro: BT_RX_MAJORITY_EN. When defined, each sample point
// takes the 2-of-3 majority of the synchronised line over the sample cycle
// and the two cycles before it; otherwise a single sample is used.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module bt_rx #(
   parameter int CLK_HZ    = 100_000_000,
   parameter int BAUD      = 9600,
   parameter int DATA_BITS = 8,
   parameter int PARITY    = 0,
   parameter int STOP_BITS = 1
) (
   input logic    clk,
   input logic    rst,
   bt_rx_if.slave bus
);
   localparam int DIV   = (CLK_HZ + BAUD / 2) / BAUD;
   localparam int HALF  = DIV / 2;
   localparam int CNT_W = $clog2(DIV);

   localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(DIV - 1);
   localparam logic [CNT_W-1:0] CNT_MID   = CNT_W'(HALF - 1);
   localparam logic [2:0]       DATA_LAST = 3'(DATA_BITS - 1);
   localparam logic [2:0]       STOP_LAST = 3'(STOP_BITS - 1);

   typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP} state_t;

   state_t               state;
   logic [CNT_W-1:0]     baud_cnt;
   logic [2:0]           bit_cnt;
   logic [DATA_BITS-1:0] shreg;
   logic                 perr_f, ferr_f;
   logic                 done;
   logic                 rxd_m, rxd_s, rxd_d;
   logic                 samp;
   logic                 par_exp;
   logic [7:0]           ext;

   logic [DATA_BITS-1:0] data_r;
   logic                 valid_r, perr_r, ferr_r, busy_r;
   logic [3:0]           choice_r, dir_r;

   // Synchroniser plus previous-value flop; all reset high so releasing reset
   // on an idle line never looks like a start edge.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rxd_m <= 1'b1;
         rxd_s <= 1'b1;
         rxd_d <= 1'b1;
      end else begin
         rxd_m <= bus.rxd;
         rxd_s <= rxd_m;
         rxd_d <= rxd_s;
      end
   end

`ifdef BT_RX_MAJORITY_EN
   // hist holds rxd_s from the two cycles before the current one; together
   // with the live rxd_s this forms the three-sample voting window.
   logic [1:0] hist;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) hist <= 2'b11;
      else      hist <= {hist[0], rxd_s};
   end

   assign samp = (hist[1] & hist[0]) | (hist[1] & rxd_s) | (hist[0] & rxd_s);
`else
   assign samp = rxd_s;
`endif

   // Even parity: parity bit equals XOR of data; odd parity: its inverse.
   assign par_exp = (PARITY == 1) ? ~(^shreg) : ^shreg;

   always_comb begin
      ext = '0;
      ext[DATA_BITS-1:0] = shreg;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state    <= IDLE;
         baud_cnt <= '0;
         bit_cnt  <= '0;
         shreg    <= '0;
         perr_f   <= 1'b0;
         ferr_f   <= 1'b0;
         done     <= 1'b0;
         data_r   <= '0;
         valid_r  <= 1'b0;
         perr_r   <= 1'b0;
         ferr_r   <= 1'b0;
         busy_r   <= 1'b0;
         choice_r <= '0;
         dir_r    <= '0;
      end else begin
         valid_r <= 1'b0;
         perr_r  <= 1'b0;
         ferr_r  <= 1'b0;
         done    <= 1'b0;

         // Result stage, one edge after the final stop sample. A new START
         // entry on this same edge clears the flags only after they are read.
         if (done) begin
            data_r <= shreg;
            ferr_r <= ferr_f;
            perr_r <= perr_f;
            if (!ferr_f && !perr_f) begin
               valid_r  <= 1'b1;
               choice_r <= ext[7:4];
               dir_r    <= ext[3:0];
            end
         end

         case (state)
            IDLE: begin
               if (rxd_d && !rxd_s) begin
                  state    <= START;
                  busy_r   <= 1'b1;
                  baud_cnt <= '0;
                  perr_f   <= 1'b0;
                  ferr_f   <= 1'b0;
               end
            end
            START: begin
               if (baud_cnt == CNT_MID) begin
                  baud_cnt <= '0;
                  if (samp) begin
                     // Line back high at mid start bit: a glitch, not a frame.
                     state  <= IDLE;
                     busy_r <= 1'b0;
                  end else begin
                     state   <= DATA;
                     bit_cnt <= '0;
                  end
               end else begin
                  baud_cnt <= baud_cnt + 1'b1;
               end
            end
            DATA: begin
               if (baud_cnt == CNT_LAST) begin
                  baud_cnt <= '0;
                  shreg    <= {samp, shreg[DATA_BITS-1:1]};
                  if (bit_cnt == DATA_LAST) begin
                     bit_cnt <= '0;
                     state   <= (PARITY != 0) ? PAR : STOP;
                  end else begin
                     bit_cnt <= bit_cnt + 1'b1;
                  end
               end else begin
                  baud_cnt <= baud_cnt + 1'b1;
               end
            end
            PAR: begin
               if (baud_cnt == CNT_LAST) begin
                  baud_cnt <= '0;
                  perr_f   <= (samp != par_exp);
                  state    <= STOP;
               end else begin
                  baud_cnt <= baud_cnt + 1'b1;
               end
            end
            STOP: begin
               if (baud_cnt == CNT_LAST) begin
                  baud_cnt <= '0;
                  if (!samp) ferr_f <= 1'b1;
                  if (bit_cnt == STOP_LAST) begin
                     // Leave at mid stop bit so an immediately following
                     // start edge is still caught.
                     bit_cnt <= '0;
                     state   <= IDLE;
                     busy_r  <= 1'b0;
                     done    <= 1'b1;
                  end else begin
                     bit_cnt <= bit_cnt + 1'b1;
                  end
               end else begin
                  baud_cnt <= baud_cnt + 1'b1;
               end
            end
            default: begin
               state  <= IDLE;
               busy_r <= 1'b0;
            end
         endcase
      end
   end

   assign bus.data       = data_r;
   assign bus.valid      = valid_r;
   assign bus.parity_err = perr_r;
   assign bus.frame_err  = ferr_r;
   assign bus.busy       = busy_r;
   assign bus.choice     = choice_r;
   assign bus.dir        = dir_r;

endmodule
